// File: rtl/gpc_pkg.sv
// Shared GPC definitions: the 1343_5 count-word format, the accumulator state
// encoding and a width-generic saturating adder.
package gpc_pkg;
  localparam int GPC1343_DST_W = 5;
  localparam int GPC1343_MAX   = 31;
  localparam int SAT_MAX_W     = 32;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} gpc_acc_state_t;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Add two values as w-bit unsigned numbers (w <= SAT_MAX_W), clamping at 2^w-1.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                       input logic [SAT_MAX_W-1:0] b,
                                       input int unsigned          w);
    logic [SAT_MAX_W:0] raw;
    logic [SAT_MAX_W:0] lim;
    sat_res_t           res;
    lim = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - {{SAT_MAX_W{1'b0}}, 1'b1};
    raw = {1'b0, a} + {1'b0, b};
    if (raw > lim) begin
      res.sum = lim[SAT_MAX_W-1:0];
      res.ovf = 1'b1;
    end else begin
      res.sum = raw[SAT_MAX_W-1:0];
      res.ovf = 1'b0;
    end
    return res;
  endfunction
endpackage

// File: rtl/gpc_sum_accumulator.sv
// Per-frame saturating column-sum collector for the GPC 1343_5 count stream.
// One registered result per frame; no input is taken while a result is pending.
module gpc_sum_accumulator
  import gpc_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [GPC1343_DST_W-1:0] in_data,
  input  logic                     in_last,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf
);

  gpc_acc_state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q, out_count_d;
  logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;

  sat_res_t         acc_res, cnt_res;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    acc_res = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(in_data), ACC_W);
    cnt_res = sat_add(SAT_MAX_W'(cnt_q), SAT_MAX_W'(1), CNT_W);
    acc_nxt = ACC_W'(acc_res.sum);
    cnt_nxt = CNT_W'(cnt_res.sum);
    ovf_nxt = ovf_q | acc_res.ovf | cnt_res.ovf;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (!flush && in_valid && in_last) state_d = DONE;
      DONE:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath updates; flush only acts while accumulating.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (state_q == ACCUM) begin
      if (flush) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (in_valid) begin
        if (in_last) begin
          out_sum_d   = acc_nxt;
          out_count_d = cnt_nxt;
          out_ovf_d   = ovf_nxt;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = acc_nxt;
          cnt_d = cnt_nxt;
          ovf_d = ovf_nxt;
        end
      end
    end
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    out_sum   = out_sum_q;
    out_count = out_count_q;
    out_ovf   = out_ovf_q;
  end

endmodule

// File: tb/tb_gpc_sum_accumulator.sv
// Directed scoreboard bench for gpc_sum_accumulator built with an 8-bit sum
// so saturation is reachable with a handful of beats.
module tb_gpc_sum_accumulator;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_last, flush, out_ready;
  logic [4:0]       in_data;
  logic             in_ready, out_valid, out_ovf;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  gpc_sum_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one cycle; block must be ready. Expected result is
  // computed here and queued when the last beat goes in.
  logic [31:0] m_sum;
  int          m_cnt;
  task automatic send(input logic [4:0] d, input logic last);
    exp_t e;
    chk("in_ready_before_beat", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = d; in_last = last;
    m_sum += 32'(d);
    m_cnt++;
    if (last) begin
      e.sum = (m_sum > 255) ? 8'hFF : m_sum[7:0];
      e.cnt = m_cnt[7:0];
      e.ovf = (m_sum > 255);
      q.push_back(e);
      m_sum = 0;
      m_cnt = 0;
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 32'(out_valid), 1);
    if (q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"}, 32'(out_sum), 32'(e.sum));
      chk({tag, "_count"}, 32'(out_count), 32'(e.cnt));
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    out_ready = 1'b1; in_data = '0; m_sum = 0; m_cnt = 0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    rst_n = 1'b1;
    tick();

    // Three-beat frame, latency one cycle, ready returns after the take.
    send(5'h0B, 1'b0); send(5'h0F, 1'b0); send(5'h05, 1'b1);
    chk("f3_in_ready_done", 32'(in_ready), 0);
    pop_check("f3");
    tick();
    chk("f3_out_valid_fall", 32'(out_valid), 0);
    chk("f3_in_ready_back", 32'(in_ready), 1);

    // Single-beat frame.
    send(5'h14, 1'b1);
    pop_check("single");
    tick();

    // Nine max beats saturate the 8-bit sum; next frame starts clean.
    for (int i = 0; i < 9; i++) send(5'h1F, i == 8);
    pop_check("sat");
    tick();
    send(5'h01, 1'b1);
    pop_check("post_sat");
    tick();

    // Backpressure with upstream pushing and a flush that must be ignored.
    out_ready = 1'b0;
    send(5'h07, 1'b0); send(5'h08, 1'b1);
    in_valid = 1'b1; in_data = 5'h01; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2);
      tick();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_sum_stable", 32'(out_sum), 32'h0F);
      chk("bp_out_count_stable", 32'(out_count), 2);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    pop_check("bp");
    tick();
    chk("bp_out_valid_fall", 32'(out_valid), 0);
    send(5'h01, 1'b1);
    pop_check("bp_next");
    tick();

    // Flush drops the partial frame and the beat presented with it.
    send(5'h10, 1'b0); send(5'h10, 1'b0);
    m_sum = 0; m_cnt = 0;
    flush = 1'b1; in_valid = 1'b1; in_data = 5'h1F; in_last = 1'b0;
    tick();
    chk("flush_in_ready", 32'(in_ready), 1);
    flush = 1'b0; in_valid = 1'b0;
    send(5'h03, 1'b1);
    pop_check("flush");
    tick();

    // Mid-frame reset.
    send(5'h1F, 1'b0); send(5'h1F, 1'b0);
    m_sum = 0; m_cnt = 0;
    rst_n = 1'b0;
    tick();
    chk("mrst_out_valid_during", 32'(out_valid), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    tick();
    chk("mrst_out_valid_after", 32'(out_valid), 0);
    send(5'h02, 1'b1);
    pop_check("mrst");
    tick();

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("queue_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpc_sum_accumulator.md
Name: gpc_sum_accumulator

Overview:
- Downstream consumer of the gpc1343_5 counter stage.
- Takes the 5-bit count word that stage produces (value 0..31) as a valid/ready stream delimited by a last flag.
- Accumulates each frame into a wide saturating sum with a beat count and a sticky overflow flag.
- Presents one result per frame on an output valid/ready port; this is the column-sum collector behind the GPC compressor layer.

Parameters:
- ACC_W, 16, accumulator/result width in bits (minimum 5).
- CNT_W, 8, beat-counter width in bits (minimum 1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream count word valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  5  GPC 1343_5 count word, unsigned 0..31.
- in_last  input  1  final beat of the current frame.
- flush  input  1  discard the partial frame (synchronous).
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  saturated frame sum.
- out_count  output  CNT_W  saturated number of beats in the frame.
- out_ovf  output  1  sum or count saturated during the frame.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - state=ACCUM, accumulator=0, counter=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 on the following cycle.
  - Reset overrides flush and both handshakes; a mid-frame reset drops the partial frame and any pending result.
- States: ACCUM, DONE.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid&in_ready.
  - On acceptance: acc_next = acc + zero-extended in_data, saturating at 2^ACC_W-1; cnt_next = cnt+1, saturating at 2^CNT_W-1.
  - ovf_next = ovf | either saturation occurred this beat.
- Last beat accepted (in_last=1):
  - out_sum, out_count and out_ovf load acc_next, cnt_next and ovf_next.
  - Internal acc, cnt and ovf clear to 0; state becomes DONE.
  - out_valid rises the cycle after the last beat is accepted (latency 1).
- DONE:
  - in_ready=0, out_valid=1; out_sum, out_count and out_ovf are held stable.
  - When out_valid&out_ready, the state returns to ACCUM next cycle.
  - There is no same-cycle input acceptance in DONE; throughput is at most one frame per (beats+1) cycles.
- flush=1 in ACCUM:
  - acc, cnt and ovf clear; any beat presented that cycle is dropped even if in_valid=1.
  - in_ready stays 1, so upstream sees a handshake and must treat that beat as consumed.
- flush=1 in DONE: no effect; the pending result is preserved.
- in_valid=0 mid-frame: state and accumulator hold indefinitely; no timeout.
- Single-beat frame (in_last on the first beat): out_sum=in_data, out_count=1.
- Saturation example: the sum clamps at 2^ACC_W-1 and ovf stays 1 until the result is emitted.
- All outputs are registered; in_ready is a decode of state only, with no combinational path from out_ready or in_valid.

Decomposition:
- Shared package gpc_pkg:
  - GPC1343_DST_W=5 and GPC1343_MAX=31.
  - gpc_acc_state_t enum {ACCUM, DONE}.
  - sat_add function (width-generic saturating add returning sum and overflow).
- No sub-module; the FSM, the accumulator and the output register live in one module.

Test Plan:
- 3-beat frame 0x0B, 0x0F, 0x05 (last on third) with out_ready=1 -> one cycle after the last beat: out_valid=1, out_sum=0x1F, out_count=3, out_ovf=0; in_ready returns to 1 the cycle after the result is taken.
- Single-beat frame in_data=0x14, in_last=1 -> out_sum=0x14, out_count=1, out_valid exactly one cycle later.
- ACC_W=8, 9 beats of 0x1F (raw sum 279) -> out_sum=0xFF, out_count=9, out_ovf=1; the next frame of 1 beat 0x01 -> out_sum=0x01, out_ovf=0.
- Backpressure: result pending, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, outputs stable; out_ready=1 -> out_valid falls next cycle and input accepted thereafter.
- Flush: beats 0x10, 0x10, then flush=1 with in_valid=1, then frame 0x03 (last) -> out_sum=0x03, out_count=1.
- Reset mid-frame: beats 0x1F, 0x1F, rst_n=0 for 1 cycle, then frame 0x02 (last) -> out_sum=0x02, out_count=1, and out_valid=0 during and right after reset.
